// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings for the IFU/LSU memory port arbiter
package mem_arbiter_pkg;

    localparam int MARB_XLEN = 32;

    typedef enum logic [1:0] {
        MARB_IDLE  = 2'd0,
        MARB_ISSUE = 2'd1,
        MARB_WAIT  = 2'd2,
        MARB_RESP  = 2'd3
    } marb_state_t;

    typedef enum logic {
        OWNER_IFU = 1'b0,
        OWNER_LSU = 1'b1
    } marb_owner_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin grant; last_grant is held by the parent
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic        i_req_ifu,
    input  logic        i_req_lsu,
    input  marb_owner_t i_last_grant,
    output logic        o_grant_valid,
    output marb_owner_t o_grant
);

    always_comb begin
        o_grant_valid = i_req_ifu | i_req_lsu;
        o_grant       = OWNER_IFU;
        if (i_req_ifu && i_req_lsu) begin
            // On a tie the side that did not win last time goes next.
            o_grant = (i_last_grant == OWNER_IFU) ? OWNER_LSU : OWNER_IFU;
        end else if (i_req_lsu) begin
            o_grant = OWNER_LSU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one word-wide memory port between IFU and LSU
// with round-robin grant, a single outstanding transaction and a response watchdog.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int XLEN        = MARB_XLEN,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ifu_req_valid,
    output logic            ifu_req_ready,
    input  logic [XLEN-1:0] ifu_addr,
    output logic            ifu_resp_valid,
    output logic [XLEN-1:0] ifu_rdata,
    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic            lsu_wen,
    input  logic [XLEN-1:0] lsu_addr,
    input  logic [XLEN-1:0] lsu_wdata,
    input  logic [3:0]      lsu_wmask,
    output logic            lsu_resp_valid,
    output logic [XLEN-1:0] lsu_rdata,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wmask,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            timeout_err
);

    localparam int            CW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] C_TO_LAST = CW'(TIMEOUT_CYC - 1);

    marb_state_t     r_state;
    marb_state_t     w_state_nxt;
    marb_owner_t     r_owner;
    marb_owner_t     r_last_grant;
    logic            r_wen;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [3:0]      r_wmask;
    logic [CW-1:0]   r_cnt;
    logic            r_timeout;
    logic [XLEN-1:0] r_rdata_ifu;
    logic [XLEN-1:0] r_rdata_lsu;

    logic            w_grant_valid;
    marb_owner_t     w_grant;
    logic            w_capture;
    logic            w_finish;
    logic            w_timeout_hit;
    logic [XLEN-1:0] w_finish_rdata;
    logic            w_unused_bits;

    assign w_unused_bits = ^{ifu_addr[1:0], lsu_addr[1:0]};

    rr_arb2 u_rr_arb2 (
        .i_req_ifu     (ifu_req_valid),
        .i_req_lsu     (lsu_req_valid),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant       (w_grant)
    );

    always_comb begin
        w_state_nxt    = r_state;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        mem_req_valid  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        w_capture      = 1'b0;
        w_finish       = 1'b0;
        w_timeout_hit  = 1'b0;
        w_finish_rdata = mem_rdata;
        case (r_state)
            MARB_IDLE: begin
                if (w_grant_valid) begin
                    ifu_req_ready = (w_grant == OWNER_IFU);
                    lsu_req_ready = (w_grant == OWNER_LSU);
                    w_capture     = 1'b1;
                    w_state_nxt   = MARB_ISSUE;
                end
            end
            MARB_ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    w_state_nxt = MARB_WAIT;
                end
            end
            MARB_WAIT: begin
                if (mem_resp_valid) begin
                    w_finish    = 1'b1;
                    w_state_nxt = MARB_RESP;
                    if (r_owner == OWNER_LSU && r_wen) begin
                        w_finish_rdata = '0;
                    end
                end else if (r_cnt == C_TO_LAST) begin
                    // Hung memory: release the port with a zero response.
                    w_finish       = 1'b1;
                    w_timeout_hit  = 1'b1;
                    w_finish_rdata = '0;
                    w_state_nxt    = MARB_RESP;
                end
            end
            MARB_RESP: begin
                ifu_resp_valid = (r_owner == OWNER_IFU);
                lsu_resp_valid = (r_owner == OWNER_LSU);
                w_state_nxt    = MARB_IDLE;
            end
            default: w_state_nxt = MARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= MARB_IDLE;
            r_owner      <= OWNER_IFU;
            r_last_grant <= OWNER_IFU;
            r_wen        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wmask      <= 4'b0000;
            r_cnt        <= '0;
            r_timeout    <= 1'b0;
            r_rdata_ifu  <= '0;
            r_rdata_lsu  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_owner      <= w_grant;
                r_last_grant <= w_grant;
                if (w_grant == OWNER_LSU) begin
                    r_wen   <= lsu_wen;
                    r_addr  <= {lsu_addr[XLEN-1:2], 2'b00};
                    r_wdata <= lsu_wdata;
                    r_wmask <= lsu_wen ? lsu_wmask : 4'b0000;
                end else begin
                    r_wen   <= 1'b0;
                    r_addr  <= {ifu_addr[XLEN-1:2], 2'b00};
                    r_wdata <= '0;
                    r_wmask <= 4'b0000;
                end
            end
            if (r_state == MARB_ISSUE && mem_req_ready) begin
                r_cnt <= '0;
            end else if (r_state == MARB_WAIT) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end
            if (w_finish) begin
                if (r_owner == OWNER_LSU) begin
                    r_rdata_lsu <= w_finish_rdata;
                end else begin
                    r_rdata_ifu <= w_finish_rdata;
                end
            end
        end
    end

    assign mem_wen     = r_wen;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign mem_wmask   = r_wmask;
    assign ifu_rdata   = r_rdata_ifu;
    assign lsu_rdata   = r_rdata_lsu;
    assign timeout_err = r_timeout;

endmodule
